// File: rtl/pipe_stage_pkg.sv
// Shared types and constants for the generic pipeline stage register.
// Optional performance counters are enabled with PIPE_STAGE_PERF_EN.
package pipe_stage_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  localparam int unsigned PERF_CNT_W = 32;

  // Default bundle widths for each pipeline boundary.
  localparam int unsigned IFID_CTRL_W  = 16;
  localparam int unsigned IFID_DATA_W  = 64;
  localparam int unsigned IDEX_CTRL_W  = 16;
  localparam int unsigned IDEX_DATA_W  = 272;
  localparam int unsigned EXMEM_CTRL_W = 16;
  localparam int unsigned EXMEM_DATA_W = 144;
  localparam int unsigned MEMWB_CTRL_W = 16;
  localparam int unsigned MEMWB_DATA_W = 80;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [PERF_CNT_W-1:0] sat_inc(input logic [PERF_CNT_W-1:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/pipe_stage_perf.sv
// Saturating stall/bubble/flush event counters for one pipeline stage.
// Instantiated by pipe_stage_reg only when PIPE_STAGE_PERF_EN is defined.
module pipe_stage_perf
  import pipe_stage_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  perf_clr,
  input  logic                  stall_evt,
  input  logic                  bubble_evt,
  input  logic                  flush_evt,
  output logic [PERF_CNT_W-1:0] stall_cnt,
  output logic [PERF_CNT_W-1:0] bubble_cnt,
  output logic [PERF_CNT_W-1:0] flush_cnt
);

  logic [PERF_CNT_W-1:0] stall_q, stall_d;
  logic [PERF_CNT_W-1:0] bubble_q, bubble_d;
  logic [PERF_CNT_W-1:0] flush_q, flush_d;

  // Next counts: clear wins over any increment.
  always_comb begin
    stall_d  = stall_q;
    bubble_d = bubble_q;
    flush_d  = flush_q;
    if (perf_clr) begin
      stall_d  = '0;
      bubble_d = '0;
      flush_d  = '0;
    end else begin
      if (stall_evt)  stall_d  = sat_inc(stall_q);
      if (bubble_evt) bubble_d = sat_inc(bubble_q);
      if (flush_evt)  flush_d  = sat_inc(flush_q);
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_q  <= '0;
      bubble_q <= '0;
      flush_q  <= '0;
    end else begin
      stall_q  <= stall_d;
      bubble_q <= bubble_d;
      flush_q  <= flush_d;
    end
  end

  assign stall_cnt  = stall_q;
  assign bubble_cnt = bubble_q;
  assign flush_cnt  = flush_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register: ctrl/data bundles under valid/ready with
// a 2-entry skid buffer so in_ready is purely registered.
// Define PIPE_STAGE_PERF_EN to add stall/bubble/flush counters and perf_clr.
module pipe_stage_reg
  import pipe_stage_pkg::*;
#(
  parameter int unsigned CTRL_W              = IDEX_CTRL_W,
  parameter int unsigned DATA_W              = IDEX_DATA_W,
  parameter bit          ZERO_DATA_ON_BUBBLE = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_PERF_EN
  ,
  input  logic                  perf_clr,
  output logic [PERF_CNT_W-1:0] stall_cnt,
  output logic [PERF_CNT_W-1:0] bubble_cnt,
  output logic [PERF_CNT_W-1:0] flush_cnt
`endif
);

  state_e            state_q, state_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d, skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
  logic              acc, pop;
  logic              load_main_in, load_main_skid, load_skid_in;

  assign in_ready  = (state_q != ST_FULL);
  assign out_valid = (state_q != ST_EMPTY);
  assign acc       = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Occupancy transitions and register load selects; flush overrides all.
  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid_in   = 1'b0;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (acc) begin
            state_d      = ST_ONE;
            load_main_in = 1'b1;
          end
        end
        ST_ONE: begin
          if (acc && pop) begin
            load_main_in = 1'b1;
          end else if (acc) begin
            state_d      = ST_FULL;
            load_skid_in = 1'b1;
          end else if (pop) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (pop) begin
            state_d        = ST_ONE;
            load_main_skid = 1'b1;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // Entry payload muxing; registers simply hold when not loaded.
  always_comb begin
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;
    if (load_main_in) begin
      main_ctrl_d = in_ctrl;
      main_data_d = in_data;
    end else if (load_main_skid) begin
      main_ctrl_d = skid_ctrl_q;
      main_data_d = skid_data_q;
    end
    if (load_skid_in) begin
      skid_ctrl_d = in_ctrl;
      skid_data_d = in_data;
    end
  end

  // State and entry registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_EMPTY;
      main_ctrl_q <= '0;
      main_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
    end else begin
      state_q     <= state_d;
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
    end
  end

  // Bubbles carry no control; data optionally zeroed too.
  assign out_ctrl = out_valid ? main_ctrl_q : '0;
  assign out_data = (ZERO_DATA_ON_BUBBLE && !out_valid) ? '0 : main_data_q;

`ifdef PIPE_STAGE_PERF_EN
  pipe_stage_perf u_perf (
    .clk        (clk),
    .reset      (reset),
    .perf_clr   (perf_clr),
    .stall_evt  (out_valid & ~out_ready),
    .bubble_evt (~out_valid),
    .flush_evt  (flush),
    .stall_cnt  (stall_cnt),
    .bubble_cnt (bubble_cnt),
    .flush_cnt  (flush_cnt)
  );
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: the stage is modelled as a FIFO of
// capacity two that is emptied by flush/reset.
module tb_pipe_stage_reg;

  localparam int unsigned CTRL_W = 16;
  localparam int unsigned DATA_W = 272;

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;
  } entry_t;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl = '0;
  logic [DATA_W-1:0] in_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
  logic              perf_clr = 1'b0;
`ifdef PIPE_STAGE_PERF_EN
  logic [31:0]       stall_cnt, bubble_cnt, flush_cnt;
  logic [31:0]       m_stall = '0, m_bubble = '0, m_flush = '0;
`endif

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  entry_t      exp_q[$];

  always #5 clk = ~clk;

  pipe_stage_reg #(
    .CTRL_W              (CTRL_W),
    .DATA_W              (DATA_W),
    .ZERO_DATA_ON_BUBBLE (1'b0)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_data  (out_data)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .perf_clr   (perf_clr),
    .stall_cnt  (stall_cnt),
    .bubble_cnt (bubble_cnt),
    .flush_cnt  (flush_cnt)
`endif
  );

  task automatic check(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] rand_data();
    logic [287:0] w;
    for (int k = 0; k < 9; k++) w[k*32 +: 32] = $urandom;
    return w[DATA_W-1:0];
  endfunction

  // Called at posedge+1; returns at the next posedge+1. Records accepted
  // entries (or a flush) into the expected queue just after the sampling edge.
  task automatic step(input logic iv, input logic [CTRL_W-1:0] c, input logic ordy,
                      input logic fl, input logic clr);
    entry_t e;
    logic   a, f;
    e.ctrl    = c;
    e.data    = rand_data();
    in_valid  = iv;
    in_ctrl   = c;
    in_data   = e.data;
    out_ready = ordy;
    flush     = fl;
    perf_clr  = clr;
    @(negedge clk);
    a = reset && in_valid && in_ready;
    f = reset && flush;
    #1;
    if (f) exp_q.delete();
    else if (a) exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare whatever the stage presents against the queue head.
  always @(negedge clk) begin
    logic ev;
    ev = exp_q.size() > 0;
    check("out_valid", out_valid, ev);
    check("in_ready", in_ready, exp_q.size() < 2);
    if (ev) begin
      check("out_ctrl", out_ctrl, exp_q[0].ctrl);
      check("out_data", out_data, exp_q[0].data);
      if (out_ready) void'(exp_q.pop_front());
    end else begin
      check("bubble_ctrl", out_ctrl, '0);
    end
    if (!reset) check("reset_data", out_data, '0);
`ifdef PIPE_STAGE_PERF_EN
    check("stall_cnt", stall_cnt, m_stall);
    check("bubble_cnt", bubble_cnt, m_bubble);
    check("flush_cnt", flush_cnt, m_flush);
    if (!reset || perf_clr) begin
      m_stall = '0; m_bubble = '0; m_flush = '0;
    end else begin
      if (ev && !out_ready && m_stall != '1) m_stall++;
      if (!ev && m_bubble != '1) m_bubble++;
      if (flush && m_flush != '1) m_flush++;
    end
`endif
  end

  initial begin
    // Reset held for 3 cycles, then released.
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    // Back-to-back stream, then two bubble cycles.
    for (int i = 1; i <= 5; i++) step(1'b1, CTRL_W'(i), 1'b1, 1'b0, 1'b0);
    repeat (2) step(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // Stall into skid, then drain in order.
    step(1'b1, 16'h00A1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h00A2, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    repeat (3) step(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // Flush while FULL with a simultaneous offered entry.
    step(1'b1, 16'h00B1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h00B2, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h00FF, 1'b0, 1'b1, 1'b0);
    repeat (2) step(1'b0, '0, 1'b1, 1'b0, 1'b0);

`ifdef PIPE_STAGE_PERF_EN
    // 4 stall cycles and 2 flush pulses, then clear.
    step(1'b0, '0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 16'h00C1, 1'b0, 1'b0, 1'b0);
    repeat (4) step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b1, 1'b0);
    check("perf_stall4", stall_cnt, 32'd4);
    check("perf_flush2", flush_cnt, 32'd2);
    step(1'b0, '0, 1'b1, 1'b0, 1'b1);
    check("perf_stall_clr", stall_cnt, '0);
    check("perf_flush_clr", flush_cnt, '0);
    check("perf_bubble_clr", bubble_cnt, '0);
`endif

    // Randomized traffic.
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 9) < 7), CTRL_W'($urandom), ($urandom_range(0, 9) < 6),
           ($urandom_range(0, 99) < 5), ($urandom_range(0, 99) < 3));

    // Asynchronous reset between edges while FULL.
    step(1'b1, 16'h00D1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h00D2, 1'b0, 1'b0, 1'b0);
    check("pre_reset_full", in_ready, 1'b0);
    in_valid = 1'b0;
    #3;
    exp_q.delete();
    reset = 1'b0;
    #1;
    check("async_valid", out_valid, 1'b0);
    check("async_ctrl", out_ctrl, '0);
    check("async_ready", in_ready, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (3) step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 50; i++)
      step(($urandom_range(0, 9) < 7), CTRL_W'($urandom), ($urandom_range(0, 9) < 5),
           1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
